// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//   Two-requester write arbiter feeding the single write port of a register
//   file. Collisions are resolved by a 1-bit round-robin pointer. The write
//   port (WE3/A3/WD3) is registered one cycle after the transfer edge.
//   Writes aimed at register 15 are accepted but suppressed, because r15 is
//   owned by the PC path; they raise a one-cycle err_r15 pulse instead.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req0/addr0/data0      requester 0 write request, address, data
//   req1/addr1/data1      requester 1 write request, address, data
//   gnt0, gnt1            combinational grants (transfer when reqN & gntN)
//   WE3, A3, WD3          registered register-file write port
//   err_r15               one-cycle pulse: accepted write targeted r15
//   wr_cnt                saturating count of committed writes
//   coll_cnt              saturating count of cycles with both requests high
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] data0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              err_r15,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  coll_cnt
);

  localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(15);

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic              r_ptr;
  logic              r_we;
  logic [ADDR_W-1:0] r_a3;
  logic [DATA_W-1:0] r_wd3;
  logic              r_err;
  logic [CNT_W-1:0]  r_wr_cnt;
  logic [CNT_W-1:0]  r_coll_cnt;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_to_r15;
  logic              w_we_next;
  logic              w_coll;

  // Grant generation; grants are masked while reset is asserted so that no
  // transfer can be acknowledged during reset.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!rst_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else if (req0 && req1) begin
      w_gnt0 = ~r_ptr;
      w_gnt1 = r_ptr;
    end else begin
      w_gnt0 = req0;
      w_gnt1 = req1;
    end
  end

  // Winner selection and write qualification (r15 writes are dropped).
  always_comb begin
    w_xfer = w_gnt0 | w_gnt1;
    w_addr = addr0;
    w_data = data0;
    if (w_gnt1) begin
      w_addr = addr1;
      w_data = data1;
    end else begin
      w_addr = addr0;
      w_data = data0;
    end
    w_to_r15  = w_xfer && (w_addr == PC_ADDR);
    w_we_next = w_xfer && (w_addr != PC_ADDR);
    w_coll    = req0 && req1;
  end

  // Priority pointer: after a transfer it points at the requester that lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (w_xfer) begin
      r_ptr <= w_gnt0;
    end else begin
      r_ptr <= r_ptr;
    end
  end

  // Registered write port; address/data hold when no transfer occurs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we  <= 1'b0;
      r_err <= 1'b0;
      r_a3  <= {ADDR_W{1'b0}};
      r_wd3 <= {DATA_W{1'b0}};
    end else begin
      r_we  <= w_we_next;
      r_err <= w_to_r15;
      if (w_xfer) begin
        r_a3  <= w_addr;
        r_wd3 <= w_data;
      end else begin
        r_a3  <= r_a3;
        r_wd3 <= r_wd3;
      end
    end
  end

  // Statistics counters, both saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt   <= {CNT_W{1'b0}};
      r_coll_cnt <= {CNT_W{1'b0}};
    end else begin
      if (w_we_next) begin
        r_wr_cnt <= sat_inc(r_wr_cnt);
      end else begin
        r_wr_cnt <= r_wr_cnt;
      end
      if (w_coll) begin
        r_coll_cnt <= sat_inc(r_coll_cnt);
      end else begin
        r_coll_cnt <= r_coll_cnt;
      end
    end
  end

  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign WE3      = r_we;
  assign A3       = r_a3;
  assign WD3      = r_wd3;
  assign err_r15  = r_err;
  assign wr_cnt   = r_wr_cnt;
  assign coll_cnt = r_coll_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Table-driven bench for regfile_write_arbiter. Each vector carries the
//   request inputs and the expected grants; the expected write-port result
//   is pushed to a scoreboard queue when the vector is driven and popped and
//   compared one edge later. Hand-written sequences cover async reset,
//   post-reset collision ordering and counter saturation.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;

  logic              clk;
  logic              rst_n;
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] data0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] data1;
  logic              gnt0;
  logic              gnt1;
  logic              WE3;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic              err_r15;
  logic [CNT_W-1:0]  wr_cnt;
  logic [CNT_W-1:0]  coll_cnt;

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .data0(data0),
    .req1(req1), .addr1(addr1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1),
    .WE3(WE3), .A3(A3), .WD3(WD3), .err_r15(err_r15),
    .wr_cnt(wr_cnt), .coll_cnt(coll_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] data0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] data1;
    logic              eg0;
    logic              eg1;
  } vec_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd3;
    logic              err;
    logic [CNT_W-1:0]  wr;
    logic [CNT_W-1:0]  coll;
  } exp_t;

  int checks = 0;
  int errors = 0;

  exp_t sb_q[$];

  logic [ADDR_W-1:0] m_a3;
  logic [DATA_W-1:0] m_wd3;
  logic [CNT_W-1:0]  m_wr;
  logic [CNT_W-1:0]  m_coll;

  vec_t tbl[12];
  vec_t col[4];

  function automatic vec_t mk(input logic r0, input logic [ADDR_W-1:0] a0,
                              input logic [DATA_W-1:0] d0, input logic r1,
                              input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.req0 = r0; v.addr0 = a0; v.data0 = d0;
    v.req1 = r1; v.addr1 = a1; v.data1 = d1;
    v.eg0 = g0; v.eg1 = g1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_a3   = '0;
    m_wd3  = '0;
    m_wr   = '0;
    m_coll = '0;
    sb_q.delete();
  endtask

  // Drive one vector, check grants, push expected write, compare after edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    req0 = v.req0; addr0 = v.addr0; data0 = v.data0;
    req1 = v.req1; addr1 = v.addr1; data1 = v.data1;
    #1;
    chk({tag, ".gnt0"}, {31'd0, gnt0}, {31'd0, v.eg0});
    chk({tag, ".gnt1"}, {31'd0, gnt1}, {31'd0, v.eg1});
    e.we  = 1'b0;
    e.err = 1'b0;
    if (v.eg0) begin
      m_a3 = v.addr0; m_wd3 = v.data0;
      e.we = (v.addr0 != 4'd15); e.err = (v.addr0 == 4'd15);
    end else if (v.eg1) begin
      m_a3 = v.addr1; m_wd3 = v.data1;
      e.we = (v.addr1 != 4'd15); e.err = (v.addr1 == 4'd15);
    end
    if (e.we && m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
    if (v.req0 && v.req1 && m_coll != 16'hFFFF) m_coll = m_coll + 16'd1;
    e.a3 = m_a3; e.wd3 = m_wd3; e.wr = m_wr; e.coll = m_coll;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk({tag, ".WE3"},      {31'd0, WE3},     {31'd0, got.we});
    chk({tag, ".A3"},       {28'd0, A3},      {28'd0, got.a3});
    chk({tag, ".WD3"},      WD3,              got.wd3);
    chk({tag, ".err_r15"},  {31'd0, err_r15}, {31'd0, got.err});
    chk({tag, ".wr_cnt"},   {16'd0, wr_cnt},  {16'd0, got.wr});
    chk({tag, ".coll_cnt"}, {16'd0, coll_cnt},{16'd0, got.coll});
  endtask

  task automatic idle_inputs();
    req0 = 1'b0; addr0 = '0; data0 = '0;
    req1 = 1'b0; addr1 = '0; data1 = '0;
  endtask

  initial begin
    // Vectors start right after reset (ptr = 0); expected grants follow the
    // round-robin pointer evolution noted per row.
    tbl[0]  = mk(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0,        1'b1, 1'b0); // ptr0->1
    tbl[1]  = mk(1'b1, 4'd1, 32'h11110001, 1'b1, 4'd2, 32'h22220002, 1'b0, 1'b1); // ptr1->0
    tbl[2]  = mk(1'b1, 4'd1, 32'h11110001, 1'b1, 4'd2, 32'h22220002, 1'b1, 1'b0); // ptr0->1
    tbl[3]  = mk(1'b0, 4'd0, 32'h0,        1'b1, 4'd15, 32'h00000BAD, 1'b0, 1'b1); // r15, ptr->0
    tbl[4]  = mk(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,        1'b0, 1'b0); // hold 0
    tbl[5]  = mk(1'b1, 4'd7, 32'h00000077, 1'b0, 4'd0, 32'h0,        1'b1, 1'b0); // ptr->1
    tbl[6]  = mk(1'b1, 4'd5, 32'h00000011, 1'b1, 4'd5, 32'h00000022, 1'b0, 1'b1); // 0x22, ptr->0
    tbl[7]  = mk(1'b1, 4'd5, 32'h00000011, 1'b1, 4'd5, 32'h00000022, 1'b1, 1'b0); // 0x11, ptr->1
    tbl[8]  = mk(1'b1, 4'd15, 32'hCAFE0015, 1'b0, 4'd0, 32'h0,       1'b1, 1'b0); // r15, ptr->1
    tbl[9]  = mk(1'b0, 4'd0, 32'h0,        1'b1, 4'd9, 32'h00000099, 1'b0, 1'b1); // ptr->0
    tbl[10] = mk(1'b1, 4'd4, 32'hA5A5A5A5, 1'b1, 4'd6, 32'h5A5A5A5A, 1'b1, 1'b0); // ptr->1
    tbl[11] = mk(1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,        1'b0, 1'b0);
    col[0]  = mk(1'b1, 4'd10, 32'h0000A000, 1'b1, 4'd11, 32'h0000B000, 1'b1, 1'b0);
    col[1]  = mk(1'b1, 4'd10, 32'h0000A000, 1'b1, 4'd11, 32'h0000B000, 1'b0, 1'b1);
    col[2]  = mk(1'b1, 4'd10, 32'h0000A000, 1'b1, 4'd11, 32'h0000B000, 1'b1, 1'b0);
    col[3]  = mk(1'b1, 4'd10, 32'h0000A000, 1'b1, 4'd11, 32'h0000B000, 1'b0, 1'b1);

    // Reset with both requests high: no grants, no counting.
    rst_n = 1'b0;
    req0 = 1'b1; addr0 = 4'd2; data0 = 32'h12345678;
    req1 = 1'b1; addr1 = 4'd4; data1 = 32'h87654321;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst.gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst.WE3", {31'd0, WE3}, 32'd0);
    chk("rst.A3", {28'd0, A3}, 32'd0);
    chk("rst.WD3", WD3, 32'd0);
    chk("rst.err_r15", {31'd0, err_r15}, 32'd0);
    chk("rst.wr_cnt", {16'd0, wr_cnt}, 32'd0);
    chk("rst.coll_cnt", {16'd0, coll_cnt}, 32'd0);
    idle_inputs();
    rst_n = 1'b1;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      apply(tbl[i], $sformatf("vec%0d", i));
    end

    // Async reset between edges while requester 0 is being granted.
    apply(mk(1'b1, 4'd8, 32'h00000088, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0), "prerst");
    chk("midrst.gnt0_before", {31'd0, gnt0}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst.WE3", {31'd0, WE3}, 32'd0);
    chk("midrst.gnt0", {31'd0, gnt0}, 32'd0);
    chk("midrst.gnt1", {31'd0, gnt1}, 32'd0);
    chk("midrst.wr_cnt", {16'd0, wr_cnt}, 32'd0);
    chk("midrst.coll_cnt", {16'd0, coll_cnt}, 32'd0);
    @(posedge clk);
    #1;
    idle_inputs();
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("postrst.WE3", {31'd0, WE3}, 32'd0);
    chk("postrst.A3", {28'd0, A3}, 32'd0);

    // Collision straight after reset: grants 0,1,0,1 with no bubble.
    for (int i = 0; i < 4; i++) begin
      apply(col[i], $sformatf("coll%0d", i));
    end
    idle_inputs();
    #1;
    chk("coll.coll_cnt", {16'd0, coll_cnt}, 32'd4);
    chk("coll.wr_cnt", {16'd0, wr_cnt}, 32'd4);

    // Saturation: 65535 writes from reset, then one more.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    req0 = 1'b1; addr0 = 4'd1; data0 = 32'h5A7A5A7A;
    repeat (65535) @(posedge clk);
    #1;
    chk("sat.wr_cnt_full", {16'd0, wr_cnt}, 32'h0000FFFF);
    @(posedge clk);
    #1;
    chk("sat.WE3", {31'd0, WE3}, 32'd1);
    chk("sat.wr_cnt_hold", {16'd0, wr_cnt}, 32'h0000FFFF);
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 32, width of write data.
- ADDR_W, 4, register address width (16 registers).
- CNT_W, 16, width of statistics counters.

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock; all state updates on posedge clk.
- rst_n  in  1  reset, asynchronous, active-low.
- req0  in  1  requester 0 write request.
- addr0  in  ADDR_W  requester 0 destination register.
- data0  in  DATA_W  requester 0 write data.
- req1  in  1  requester 1 write request.
- addr1  in  ADDR_W  requester 1 destination register.
- data1  in  DATA_W  requester 1 write data.
- gnt0  out  1  requester 0 transfer accepted this cycle.
- gnt1  out  1  requester 1 transfer accepted this cycle.
- WE3  out  1  register-file write enable.
- A3  out  ADDR_W  register-file write address.
- WD3  out  DATA_W  register-file write data.
- err_r15  out  1  one-cycle pulse: accepted request targeted register 15.
- wr_cnt  out  CNT_W  count of committed register-file writes.
- coll_cnt  out  CNT_W  count of cycles with req0 and req1 both high.

Function
REQ-003 Transfer rule: a transfer SHALL occur on a rising edge where reqN=1 and gntN=1; the requester holds reqN, addrN and dataN stable until that edge.
REQ-004 gnt0 and gnt1 SHALL be combinational from req0, req1 and the priority pointer, and SHALL never both be 1.
REQ-005 If exactly one reqN=1, the arbiter SHALL assert that gntN in the same cycle.
REQ-006 If both requests are 1, the arbiter SHALL grant the requester selected by the 1-bit priority pointer ptr (0 selects requester 0).
REQ-007 After every transfer, ptr SHALL load the index of the requester not granted; with no transfer, ptr SHALL hold.
REQ-008 Two continuously asserted requesters SHALL therefore alternate grants every cycle.
REQ-009 Write-port outputs SHALL be registered, giving a latency of exactly 1 cycle: after a transfer edge, A3 and WD3 equal the granted addr and data, and WE3=1 for one cycle.
REQ-010 If the granted address equals 15, the transfer SHALL still complete (gnt asserted), WE3 SHALL be 0 on the following cycle, and err_r15 SHALL pulse 1 for that cycle; register 15 is owned by the PC path.
REQ-011 With no transfer, WE3 SHALL be 0 on the next cycle, A3 and WD3 SHALL hold their last values, and err_r15 SHALL be 0.
REQ-012 wr_cnt SHALL increment on each edge where WE3 is loaded to 1, and SHALL saturate at all-ones (no wrap).
REQ-013 coll_cnt SHALL increment on each edge where req0=1 and req1=1, and SHALL saturate at all-ones.
REQ-014 Both requesters targeting the same address in the same cycle SHALL be serialized by REQ-006, so the later-granted data is the final register value.
REQ-015 Back-to-back writes SHALL be supported at a rate of 1 per cycle with no bubble.

Reset
REQ-016 When rst_n=0, regardless of clk, the following SHALL be forced: WE3=0, A3=0, WD3=0, err_r15=0, wr_cnt=0, coll_cnt=0, ptr=0.
REQ-017 While rst_n=0, gnt0 and gnt1 SHALL be 0 irrespective of requests; no transfer occurs.
REQ-018 Reset asserted mid-operation SHALL discard any pending write; a grant in the reset cycle SHALL NOT produce WE3 after release.
REQ-019 After rst_n deasserts, the first edge SHALL behave per REQ-005/006 with ptr=0.

Verification
REQ-020 Single request: req0=1, addr0=3, data0=0xDEADBEEF for 1 cycle -> gnt0=1 that cycle; next cycle WE3=1, A3=3, WD3=0xDEADBEEF; wr_cnt=1.
REQ-021 Collision: after reset, req0 and req1 held high for 4 cycles -> gnt order 0,1,0,1; WE3=1 for 4 consecutive cycles; coll_cnt=4.
REQ-022 R15 guard: req1=1, addr1=15 -> gnt1=1; next cycle WE3=0 and err_r15=1; wr_cnt unchanged.
REQ-023 Same address: both requesters target address 5 with data 0x11 and 0x22, ptr=1 -> writes 0x22 then 0x11 on consecutive cycles.
REQ-024 Async reset: rst_n pulled low between edges while a request is granted -> WE3, gnt0 and gnt1 drop to 0 immediately; counters read 0; no write after release until a new request.
REQ-025 Saturation: preload by driving 65535 writes, then one more -> wr_cnt stays 0xFFFF.
